hvsync_generator: RTL and testbench

HVSYNC_GENERATOR -- requirements
Module: hvsync_generator

---
 rtl/hvsync_generator.sv | 66 ++++++
 tb/tb_hvsync_generator.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/hvsync_generator.sv
// 640x480@60 VGA timing generator: pixel/line counters with registered sync and display-enable outputs.
// Define HVSYNC_SYNC_ACTIVE_HIGH_EN for active-high syncs; otherwise both syncs are active-low.
module hvsync_generator (
    input  logic       clk,
    input  logic       reset,
    output logic       vga_h_sync,
    output logic       vga_v_sync,
    output logic       inDisplayArea,
    output logic [9:0] CounterX,
    output logic [9:0] CounterY
);

    localparam logic [9:0] H_VISIBLE    = 10'd640;
    localparam logic [9:0] H_SYNC_START = 10'd656;
    localparam logic [9:0] H_SYNC_END   = 10'd751;
    localparam logic [9:0] H_LAST       = 10'd799;
    localparam logic [9:0] V_VISIBLE    = 10'd480;
    localparam logic [9:0] V_SYNC_START = 10'd490;
    localparam logic [9:0] V_SYNC_END   = 10'd491;
    localparam logic [9:0] V_LAST       = 10'd524;

`ifdef HVSYNC_SYNC_ACTIVE_HIGH_EN
    localparam logic SYNC_ACTIVE = 1'b1;
`else
    localparam logic SYNC_ACTIVE = 1'b0;
`endif

    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       next_h_active;
    logic       next_v_active;
    logic       next_display;

    // Outputs are decoded from the next counter values so they line up with the counters after the edge.
    always_comb begin
        next_x = CounterX + 10'd1;
        next_y = CounterY;
        if (CounterX == H_LAST) begin
            next_x = 10'd0;
            if (CounterY == V_LAST)
                next_y = 10'd0;
            else
                next_y = CounterY + 10'd1;
        end
        next_h_active = (next_x >= H_SYNC_START) && (next_x <= H_SYNC_END);
        next_v_active = (next_y >= V_SYNC_START) && (next_y <= V_SYNC_END);
        next_display  = (next_x < H_VISIBLE) && (next_y < V_VISIBLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            CounterX      <= 10'd0;
            CounterY      <= 10'd0;
            inDisplayArea <= 1'b1;
            vga_h_sync    <= ~SYNC_ACTIVE;
            vga_v_sync    <= ~SYNC_ACTIVE;
        end else begin
            CounterX      <= next_x;
            CounterY      <= next_y;
            inDisplayArea <= next_display;
            vga_h_sync    <= next_h_active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
            vga_v_sync    <= next_v_active ? SYNC_ACTIVE : ~SYNC_ACTIVE;
        end
    end

endmodule

// File: tb/tb_hvsync_generator.sv
// Self-checking bench for hvsync_generator: per-pixel scoreboard against a reference timing model,
// plus async reset, sync pulse widths and full-frame length checks.
module tb_hvsync_generator;

`ifdef HVSYNC_SYNC_ACTIVE_HIGH_EN
    localparam logic ACT = 1'b1;
`else
    localparam logic ACT = 1'b0;
`endif

    typedef struct packed {
        logic [9:0] x;
        logic [9:0] y;
        logic       de;
        logic       hs;
        logic       vs;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       vga_h_sync;
    logic       vga_v_sync;
    logic       inDisplayArea;
    logic [9:0] CounterX;
    logic [9:0] CounterY;

    int total = 0;
    int bad   = 0;

    vec_t       exp_q[$];
    vec_t       obs;
    vec_t       exp_v;
    logic [9:0] mx;
    logic [9:0] my;

    hvsync_generator dut (
        .clk           (clk),
        .reset         (reset),
        .vga_h_sync    (vga_h_sync),
        .vga_v_sync    (vga_v_sync),
        .inDisplayArea (inDisplayArea),
        .CounterX      (CounterX),
        .CounterY      (CounterY)
    );

    always #5 clk = ~clk;

    function automatic vec_t model_vec(input logic [9:0] x, input logic [9:0] y);
        vec_t v;
        v.x  = x;
        v.y  = y;
        v.de = (x <= 10'd639) && (y <= 10'd479);
        v.hs = (x >= 10'd656 && x <= 10'd751) ? ACT : ~ACT;
        v.vs = (y >= 10'd490 && y <= 10'd491) ? ACT : ~ACT;
        return v;
    endfunction

    function automatic vec_t sample();
        vec_t v;
        v.x  = CounterX;
        v.y  = CounterY;
        v.de = inDisplayArea;
        v.hs = vga_h_sync;
        v.vs = vga_v_sync;
        return v;
    endfunction

    task automatic check(input string tag, input vec_t o, input vec_t e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got x=%0d y=%0d de=%b hs=%b vs=%b exp x=%0d y=%0d de=%b hs=%b vs=%b",
                   tag, o.x, o.y, o.de, o.hs, o.vs, e.x, e.y, e.de, e.hs, e.vs);
        end
    endtask

    task automatic check_int(input string tag, input int o, input int e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s got=%0d exp=%0d", tag, o, e);
        end
    endtask

    // One pixel: advance the reference model at the edge, queue its expectation, compare mid-cycle.
    task automatic step();
        @(posedge clk);
        if (mx == 10'd799) begin
            mx = 10'd0;
            my = (my == 10'd524) ? 10'd0 : my + 10'd1;
        end else begin
            mx = mx + 10'd1;
        end
        exp_q.push_back(model_vec(mx, my));
        @(negedge clk);
        exp_v = exp_q.pop_front();
        obs   = sample();
        check("pixel", obs, exp_v);
    endtask

    initial begin
        int frame_clks;
        int hs_line0;
        int vs_clks;
        int wraps_ok;
        logic [9:0] prev_x;
        logic [9:0] prev_y;

        reset = 1'b1;
        #1;
        check("reset_t0", sample(), model_vec(10'd0, 10'd0));
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        mx = 10'd0;
        my = 10'd0;

        step();
        check_int("first_edge_x", int'(CounterX), 1);

        for (int i = 0; i < 999; i++) step();

        // Mid-line reset must act before the next clock edge.
        #2 reset = 1'b1;
        #1;
        check("async_reset", sample(), model_vec(10'd0, 10'd0));
        @(posedge clk);
        @(negedge clk);
        check("reset_hold", sample(), model_vec(10'd0, 10'd0));
        reset = 1'b0;
        mx = 10'd0;
        my = 10'd0;

        frame_clks = 0;
        hs_line0   = 0;
        vs_clks    = 0;
        wraps_ok   = 0;
        prev_x     = 10'd0;
        prev_y     = 10'd0;
        do begin
            step();
            frame_clks++;
            if (obs.y == 10'd0 && obs.hs === ACT) hs_line0++;
            if (obs.vs === ACT) vs_clks++;
            if (prev_x == 10'd799 && obs.x == 10'd0 &&
                obs.y == ((prev_y == 10'd524) ? 10'd0 : prev_y + 10'd1))
                wraps_ok++;
            prev_x = obs.x;
            prev_y = obs.y;
        end while (!(obs.x == 10'd0 && obs.y == 10'd0) && frame_clks < 430000 && bad < 50);

        check_int("frame_clocks", frame_clks, 420000);
        check_int("hsync_clocks_line0", hs_line0, 96);
        check_int("vsync_clocks_frame", vs_clks, 1600);
        check_int("line_wraps", wraps_ok, 525);

        for (int i = 0; i < 5; i++) step();
        check_int("queue_drained", exp_q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
